lcd_scroll_ctrl: RTL and testbench

//   Sequencer for the 2x16 LCD text datapath: owns the row_A/row_B 128-bit buffers fed to the LCD driver.

---
 rtl/lcd_scroll_ctrl.sv | 151 +++++++++++++++
 tb/tb_lcd_scroll_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scroll_ctrl.sv
// Scroll sequencer for a 2x16 LCD. It owns the two 128-bit row buffers and rotates them on a divided tick.
// Define LCD_SCROLL_STEP_EN to add a btn_step input that single-steps the rows while paused.
module lcd_scroll_ctrl #(
    parameter int           TICK_CYCLES = 100_000_000,
    parameter int           CNT_W       = 27,
    parameter logic [127:0] INIT_A      = "ABCDEFGHIJKLMNOP",
    parameter logic [127:0] INIT_B      = "QRSTUVWXYZABCDEF"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_toggle,
    input  logic         btn_dir,
    input  logic         btn_speed,
    input  logic         btn_clear,
`ifdef LCD_SCROLL_STEP_EN
    input  logic         btn_step,
`endif
    output logic [127:0] row_A,
    output logic [127:0] row_B,
    output logic         running,
    output logic         dir,
    output logic [1:0]   speed_lvl,
    output logic         update
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PM1_L0 = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PM1_L1 = CNT_W'((TICK_CYCLES >> 1) - 1);
    localparam logic [CNT_W-1:0] PM1_L2 = CNT_W'((TICK_CYCLES >> 2) - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       row_a_q, row_a_d;
    logic [127:0]       row_b_q, row_b_d;
    logic               running_q, running_d;
    logic               dir_q, dir_d;
    logic [1:0]         speed_q, speed_d;
    logic               update_q, update_d;
    logic               do_shift;
    logic [CNT_W-1:0]   period_m1;

    always_comb begin
        case (speed_q)
            2'd1:    period_m1 = PM1_L1;
            2'd2:    period_m1 = PM1_L2;
            default: period_m1 = PM1_L0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_a_d  = row_a_q;
        row_b_d  = row_b_q;
        update_d = 1'b0;
        do_shift = 1'b0;
        dir_d    = dir_q ^ btn_dir;
        speed_d  = speed_q;
        if (btn_speed) begin
            speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
        end

        // Clear beats toggle beats tick; dir/speed still update alongside clear.
        if (btn_clear) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            row_a_d  = INIT_A;
            row_b_d  = INIT_B;
            update_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_toggle) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (btn_toggle) begin
                        state_d = ST_PAUSE;
                    end else if (cnt_q >= period_m1) begin
                        cnt_d    = '0;
                        do_shift = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (btn_toggle) begin
                        state_d = ST_RUN;
                    end
`ifdef LCD_SCROLL_STEP_EN
                    else if (btn_step) begin
                        do_shift = 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The shift uses the pre-toggle direction when btn_dir arrives on the same edge.
        if (do_shift) begin
            update_d = 1'b1;
            if (!dir_q) begin
                row_a_d = {row_a_q[119:0], row_a_q[127:120]};
                row_b_d = {row_b_q[7:0], row_b_q[127:8]};
            end else begin
                row_a_d = {row_a_q[7:0], row_a_q[127:8]};
                row_b_d = {row_b_q[119:0], row_b_q[127:120]};
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            row_a_q   <= INIT_A;
            row_b_q   <= INIT_B;
            running_q <= 1'b0;
            dir_q     <= 1'b0;
            speed_q   <= 2'd0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_a_q   <= row_a_d;
            row_b_q   <= row_b_d;
            running_q <= running_d;
            dir_q     <= dir_d;
            speed_q   <= speed_d;
            update_q  <= update_d;
        end
    end

    assign row_A     = row_a_q;
    assign row_B     = row_b_q;
    assign running   = running_q;
    assign dir       = dir_q;
    assign speed_lvl = speed_q;
    assign update    = update_q;

endmodule

// File: tb/tb_lcd_scroll_ctrl.sv
// Scoreboard bench for lcd_scroll_ctrl with TICK_CYCLES=8: expected rows are queued per driven edge
// and popped whenever the DUT raises update; spec vectors are also checked against literal strings.
module tb_lcd_scroll_ctrl;

    localparam int           TICK   = 8;
    localparam logic [127:0] INIT_A = "ABCDEFGHIJKLMNOP";
    localparam logic [127:0] INIT_B = "QRSTUVWXYZABCDEF";
`ifdef LCD_SCROLL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         btn_toggle, btn_dir, btn_speed, btn_clear;
`ifdef LCD_SCROLL_STEP_EN
    logic         btn_step;
`endif
    logic [127:0] row_A, row_B;
    logic         running, dir, update;
    logic [1:0]   speed_lvl;

    always #5 clk = ~clk;

    lcd_scroll_ctrl #(
        .TICK_CYCLES (TICK),
        .CNT_W       (4),
        .INIT_A      (INIT_A),
        .INIT_B      (INIT_B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_toggle (btn_toggle),
        .btn_dir    (btn_dir),
        .btn_speed  (btn_speed),
        .btn_clear  (btn_clear),
`ifdef LCD_SCROLL_STEP_EN
        .btn_step   (btn_step),
`endif
        .row_A      (row_A),
        .row_B      (row_B),
        .running    (running),
        .dir        (dir),
        .speed_lvl  (speed_lvl),
        .update     (update)
    );

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
    } rows_t;

    rows_t        sb_q[$];
    int           tests_run = 0;
    int           tests_failed = 0;

    // Reference model: 0=IDLE 1=RUN 2=PAUSE
    int           m_state, m_cnt, m_spd;
    bit           m_dir, m_upd;
    logic [127:0] m_a, m_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Character-wise rotation: char i sits at bits [127-8i -: 8].
    function automatic logic [127:0] rot_chars(input logic [127:0] x, input bit to_left);
        logic [7:0]   ch [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) ch[i] = x[127-8*i -: 8];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = to_left ? ch[(i+1)%16] : ch[(i+15)%16];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_spd = 0; m_dir = 0; m_upd = 0;
        m_a = INIT_A; m_b = INIT_B;
        sb_q.delete();
    endtask

    task automatic model_step(input bit t, input bit d, input bit s, input bit c, input bit st);
        int p;
        bit sh;
        rows_t e;
        p = TICK >> m_spd;
        sh = 0;
        m_upd = 0;
        if (c) begin
            m_state = 0; m_cnt = 0; m_a = INIT_A; m_b = INIT_B; m_upd = 1;
        end else if (m_state == 0) begin
            if (t) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            if (t) m_state = 2;
            else if (m_cnt >= p - 1) begin m_cnt = 0; sh = 1; end
            else m_cnt++;
        end else begin
            if (t) m_state = 1;
            else if (st && STEP_EN) sh = 1;
        end
        if (sh) begin
            m_a = rot_chars(m_a, !m_dir);
            m_b = rot_chars(m_b, m_dir);
            m_upd = 1;
        end
        if (d) m_dir = !m_dir;
        if (s) m_spd = (m_spd == 2) ? 0 : m_spd + 1;
        if (m_upd) begin
            e.a = m_a; e.b = m_b;
            sb_q.push_back(e);
        end
    endtask

    task automatic cycle(input bit t, input bit d, input bit s, input bit c, input bit st);
        rows_t e;
        btn_toggle = t; btn_dir = d; btn_speed = s; btn_clear = c;
`ifdef LCD_SCROLL_STEP_EN
        btn_step = st;
`endif
        model_step(t, d, s, c, st);
        @(posedge clk);
        #1;
        check("update", update, m_upd);
        check("status", {running, dir, speed_lvl}, {(m_state == 1), m_dir, 2'(m_spd)});
        if (update) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_row_A", row_A, e.a);
                check("sb_row_B", row_B, e.b);
            end
        end else if (m_upd && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        btn_toggle = 0; btn_dir = 0; btn_speed = 0; btn_clear = 0;
`ifdef LCD_SCROLL_STEP_EN
        btn_step = 0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic check_rows(input string tag, input logic [127:0] ea, input logic [127:0] eb);
        check({tag, "_A"}, row_A, ea);
        check({tag, "_B"}, row_B, eb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        btn_toggle = 0; btn_dir = 0; btn_speed = 0; btn_clear = 0;
`ifdef LCD_SCROLL_STEP_EN
        btn_step = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_rows("reset", INIT_A, INIT_B);
        check("reset_flags", {running, dir, speed_lvl, update}, 5'b0);

        // Idle: nothing moves
        idle(50);
        check_rows("idle50", "ABCDEFGHIJKLMNOP", "QRSTUVWXYZABCDEF");

        // Start, first shift on 8th RUN edge
        cycle(1, 0, 0, 0, 0);
        check("running_after_toggle", running, 1'b1);
        idle(7);
        check_rows("pre_shift", "ABCDEFGHIJKLMNOP", "QRSTUVWXYZABCDEF");
        idle(1);
        check_rows("shift1", "BCDEFGHIJKLMNOPA", "FQRSTUVWXYZABCDE");
        idle(16);
        check_rows("shift3", "DEFGHIJKLMNOPABC", "DEFQRSTUVWXYZABC");

        // Pause at cnt=3, resume: shift on 5th RUN edge
        idle(3);
        cycle(1, 0, 0, 0, 0);
        idle(100);
        check_rows("paused", "DEFGHIJKLMNOPABC", "DEFQRSTUVWXYZABC");
        cycle(1, 0, 0, 0, 0);
        idle(4);
        check_rows("resume4", "DEFGHIJKLMNOPABC", "DEFQRSTUVWXYZABC");
        idle(1);
        check_rows("resume5", "EFGHIJKLMNOPABCD", "CDEFQRSTUVWXYZAB");

        // Reverse direction in IDLE
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(8);
        check_rows("dir1", "PABCDEFGHIJKLMNO", "RSTUVWXYZABCDEFQ");
        idle(3);
        cycle(0, 1, 0, 0, 0);
        idle(10);

        // Speed levels
        cycle(0, 0, 1, 0, 0);
        idle(5);
        cycle(0, 0, 1, 0, 0);
        check("speed2", speed_lvl, 2'd2);
        idle(12);
        cycle(0, 0, 1, 0, 0);
        check("speed0", speed_lvl, 2'd0);
        idle(20);

        // Random pulses, including dir on shift edges and clears
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 8);
        end

        // clear+toggle mid-RUN
        for (int k = 0; k < 3 && m_state != 1; k++) cycle(1, 0, 0, 0, 0);
        idle(3);
        cycle(1, 0, 0, 1, 0);
        check("clr_tog_running", running, 1'b0);
        check("clr_tog_update", update, 1'b1);
        check_rows("clr_tog", INIT_A, INIT_B);
        idle(20);

        // Single step while paused (no effect without the step option)
        cycle(1, 0, 0, 0, 0);
        idle(TICK);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        idle(3);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        idle(5);

        // Async reset mid-RUN with non-default dir/speed
        if (!m_dir) cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_rows("async_rst", INIT_A, INIT_B);
        check("async_rst_flags", {running, dir, speed_lvl, update}, 5'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1, 0, 0, 0, 0);
        idle(8);
        check_rows("post_rst_shift", "BCDEFGHIJKLMNOPA", "FQRSTUVWXYZABCDE");

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
